// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: one cycle per state, so beq/j take 3 cycles, R-type/sw/addi 4, lw 5 and an illegal opcode 2.
// Backpressure: none; the machine never stalls, and synchronous reset aborts any instruction on the next edge.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RCOMP    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;      // opcode captured in DECODE; MEMADDR steers on this, not on live Op
    logic       illegal;

    // State register and opcode latch; reset returns to FETCH and clears the latched opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= 6'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= Op;
            end
        end
    end

    // Next-state decode; unsupported opcodes in DECODE flag IllegalOp and fall back to FETCH.
    always_comb begin
        state_nxt = S_FETCH;
        illegal   = 1'b0;
        case (state)
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_RTYPE: state_nxt = S_EXECUTE;
                    OP_LW:    state_nxt = S_MEMADDR;
                    OP_SW:    state_nxt = S_MEMADDR;
                    OP_BEQ:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    OP_ADDI:  state_nxt = S_ADDIEX;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                if (op_q == OP_LW) begin
                    state_nxt = S_MEMREAD;
                end else if (op_q == OP_SW) begin
                    state_nxt = S_MEMWRITE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEMREAD: state_nxt = S_MEMWB;
            S_EXECUTE: state_nxt = S_RCOMP;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Moore output decode; everything is held at 0 while reset is high so no partial write escapes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        IllegalOp   = 1'b0;
        if (!reset) begin
            IllegalOp = illegal;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RCOMP: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB:   RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign State = state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle CPU datapath. It decodes the instruction opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback steps. It drives every datapath enable and select, including the 2-bit `PCSource` consumed by the PC-input multiplexer. It is a Moore machine: outputs depend only on the current state, except for the reset gating described below.

## Interface

Parameters: none. Opcodes are fixed.

Ports:
- `clk` in 1: single system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `Op` in 6: opcode field, `IR[31:26]`; sampled only in DECODE.
- `PCWrite` out 1: unconditional PC load enable.
- `PCWriteCond` out 1: PC load enable, qualified by ALU Zero in the datapath.
- `PCSource` out 2: PC-input mux select; 00 = ALU result, 01 = ALUOut register, 10 = jump target. 11 is never driven.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register load enable.
- `MemtoReg` out 1: register writeback data select; 1 = MDR.
- `RegDst` out 1: destination register select; 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = A register.
- `ALUSrcB` out 2: ALU B select; 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp` out 2: ALU control; 00 = add, 01 = subtract, 10 = use funct field.
- `State` out 4: current state encoding, for debug.
- `IllegalOp` out 1: one-cycle pulse when DECODE sees an unsupported opcode.

## Operation

State encodings:
- 0 FETCH
- 1 DECODE
- 2 MEMADDR
- 3 MEMREAD
- 4 MEMWB
- 5 MEMWRITE
- 6 EXECUTE
- 7 RCOMP
- 8 BRANCH
- 9 JUMP
- 10 ADDIEX
- 11 ADDIWB

Encodings 12–15 are unreachable. If one is ever entered, the next state is FETCH and all outputs are 0.

Outputs per state. Any output not listed for a state is 0.
- FETCH: `MemRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCWrite`=1, `PCSource`=00.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. This computes the branch target into ALUOut.
- MEMADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- MEMREAD: `MemRead`=1, `IorD`=1.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
- MEMWRITE: `MemWrite`=1, `IorD`=1.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
- RCOMP: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
- JUMP: `PCWrite`=1, `PCSource`=10.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.

Transitions:
- FETCH → DECODE.
- DECODE, by `Op`:
  - 000000 (R-type) → EXECUTE
  - 100011 (lw) → MEMADDR
  - 101011 (sw) → MEMADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with `IllegalOp`=1 for that DECODE cycle.
- MEMADDR: → MEMREAD if the latched opcode is lw; → MEMWRITE if it is sw.
- MEMREAD → MEMWB.
- EXECUTE → RCOMP.
- ADDIEX → ADDIWB.
- MEMWB, MEMWRITE, RCOMP, BRANCH, JUMP, ADDIWB → FETCH.

The opcode is latched into an internal 6-bit register in DECODE. MEMADDR branches on that latched value, not on live `Op`.

## Timing

Reset:
- A rising edge of `clk` with `reset`=1 sets the state to FETCH and clears the latched opcode to 0.
- While `reset`=1, the following outputs are forced to 0 regardless of state: `PCWrite`, `PCWriteCond`, `MemWrite`, `RegWrite`, `IRWrite`, `MemRead`, `IllegalOp`.
- `PCSource`, `ALUSrcA`, `ALUSrcB`, `ALUOp`, `IorD`, `MemtoReg`, `RegDst` are 0 while `reset`=1.
- `State` reads 0 after the first reset edge.
- Reset asserted mid-instruction aborts that instruction on the next edge. No partial write occurs in the reset cycle.
- First cycle after reset deasserts is FETCH, with its full output set.

Instruction latency in cycles, counted from FETCH through the last state:
- beq: 3
- j: 3
- R-type: 4
- sw: 4
- addi: 4
- lw: 5
- illegal opcode: 2

Exactly one cycle per state; there are no stalls.

- `PCSource` transitions only at state boundaries.
- In any state where neither `PCWrite` nor `PCWriteCond` is 1, `PCSource` is 00.
- `IllegalOp` is combinational from state and `Op`, and is valid only in the DECODE cycle.

## Test plan

- Reset held 3 cycles, then released, `Op`=000000: all write enables are 0 during reset. Following cycles show `State` 0, 1, 6, 7, 0. `RegWrite`=1 with `RegDst`=1 only in state 7.
- lw (`Op`=100011): `State` 0, 1, 2, 3, 4, 0. `IorD`=1 and `MemRead`=1 in state 3. `MemtoReg`=1 and `RegWrite`=1 in state 4. `Op` changed to 101011 during state 2 must not divert the path to MEMWRITE.
- beq (`Op`=000100), then j (`Op`=000010): beq gives `PCSource`=01, `PCWriteCond`=1, `ALUOp`=01 in state 8. j gives `PCSource`=10, `PCWrite`=1 in state 9. Each returns to FETCH after 3 cycles.
- sw then addi: sw shows `State` 0, 1, 2, 5, 0 with `MemWrite`=1 only in state 5. addi shows `State` 0, 1, 10, 11, 0 with `ALUSrcB`=10 in state 10 and `RegWrite`=1, `RegDst`=0 in state 11.
- Illegal `Op`=111111: `IllegalOp`=1 for exactly the DECODE cycle, then FETCH. No register or memory write occurs.
- Reset asserted during state 3 of an lw: next `State` is 0. No `RegWrite` pulse occurs. Across all runs, `PCSource` is never 11.
